// File: rtl/byte_store_unit.sv
// Narrowing byte store: accepts one word and emits it as one sign-checked byte
// (byte mode) or as two bytes, low first (word mode). Optional macro BYTE_STORE_SATURATE_EN
// clamps overflowing byte stores to the signed byte limits instead of truncating.
module byte_store_unit #(
    parameter int data_width = 16,
    parameter int byte_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_byte_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [byte_width-1:0] out_data,
    output logic                  out_last,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t                state_q;
    logic [byte_width-1:0] hi_q;
    logic                  out_valid_q;
    logic [byte_width-1:0] out_data_q;
    logic                  out_last_q;
    logic                  overflow_q;

    logic [byte_width-1:0] lo_in;
    logic [byte_width-1:0] hi_in;
    logic                  ovf_in;
    logic [byte_width-1:0] byte_d;

    assign lo_in  = in_data[byte_width-1:0];
    assign hi_in  = in_data[data_width-1:byte_width];
    // The word fits a signed byte only if the upper half is pure sign extension.
    assign ovf_in = (hi_in != {byte_width{lo_in[byte_width-1]}});

`ifdef BYTE_STORE_SATURATE_EN
    always_comb begin
        byte_d = lo_in;
        if (ovf_in)
            byte_d = hi_in[byte_width-1] ? {1'b1, {(byte_width-1){1'b0}}}
                                         : {1'b0, {(byte_width-1){1'b1}}};
    end
`else
    assign byte_d = lo_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= LO;
                        hi_q        <= hi_in;
                        out_valid_q <= 1'b1;
                        out_data_q  <= in_byte_mode ? byte_d : lo_in;
                        out_last_q  <= in_byte_mode;
                        overflow_q  <= in_byte_mode & ovf_in;
                    end
                end
                LO: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            overflow_q  <= 1'b0;
                        end else begin
                            state_q    <= HI;
                            out_data_q <= hi_q;
                            out_last_q <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_last_q  <= 1'b0;
                        overflow_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_last_q  <= 1'b0;
                    overflow_q  <= 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so the port reads 0 while held and 1 the cycle it releases.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_byte_store_unit.sv
// Randomized scoreboard bench for byte_store_unit with directed corner cases.
module tb_byte_store_unit;
    localparam int DW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_byte_mode;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          overflow;

    logic rand_mode;
    logic man_ready;
    logic rnd_ready;
    assign out_ready = rand_mode ? rnd_ready : man_ready;

    byte_store_unit #(.data_width(DW), .byte_width(BW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_byte_mode(in_byte_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [BW+1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed-integer range test, not bit pattern matching.
    task automatic push_expected(input logic [DW-1:0] d, input logic m);
        int v;
        logic fits;
        logic [BW-1:0] b;
        v = $signed(d);
        if (m) begin
            fits = (v >= -(2 ** (BW - 1))) && (v <= (2 ** (BW - 1)) - 1);
            b = d[BW-1:0];
`ifdef BYTE_STORE_SATURATE_EN
            if (!fits) b = (v < 0) ? BW'(2 ** (BW - 1)) : BW'((2 ** (BW - 1)) - 1);
`endif
            sb.push_back({b, 1'b1, !fits});
        end else begin
            sb.push_back({d[BW-1:0], 1'b0, 1'b0});
            sb.push_back({d[DW-1:BW], 1'b1, 1'b0});
        end
    endtask

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: protocol checks plus scoreboard pop on every output handshake.
    logic          prev_stall = 1'b0;
    logic          acc_prev   = 1'b0;
    logic          done_prev  = 1'b0;
    logic [BW+1:0] prev_out   = '0;
    always @(negedge clk) begin
        logic [BW+1:0] exp;
        if (reset) begin
            prev_stall = 1'b0;
            acc_prev   = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (acc_prev) chk("latency_out_valid", out_valid, 1);
            if (done_prev) chk("bubble_in_ready", in_ready, 1);
            chk("ready_vs_valid", in_ready, !out_valid);
            if (!out_valid) chk("overflow_idle", overflow, 0);
            if (prev_stall) chk("stall_hold", {out_valid, out_data, out_last, overflow}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_byte: got %0h, expected no output at %0t", out_data, $time);
                end else begin
                    exp = sb.pop_front();
                    chk("byte_last_ovf", {out_data, out_last, overflow}, exp);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_data, out_last, overflow};
            acc_prev   = in_valid && in_ready;
            done_prev  = out_valid && out_ready && out_last;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic m);
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = d;
        in_byte_mode = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready && !reset) begin
                acc = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
        end else begin
            push_expected(d, m);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1);
    endtask

    logic [DW-1:0] corners [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] r;
        logic [DW-1:0] d;
        corners = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_byte_mode = 1'b0;
        man_ready = 1'b1;
        rand_mode = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        send(16'hFFF0, 1'b1);
        send(16'h0123, 1'b1);
        send(16'h8000, 1'b1);
        send(16'hBEEF, 1'b0);
        drain();

        // Stall in LO with an in_valid pulse that must be ignored.
        man_ready = 1'b0;
        send(16'hBEEF, 1'b0);
        in_valid = 1'b1;
        in_data = 16'h5555;
        in_byte_mode = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_lo_data", out_data, 8'hEF);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        man_ready = 1'b1;
        drain();

        // Reset while HI holds the upper byte: it must never appear.
        man_ready = 1'b0;
        send(16'h1234, 1'b0);
        man_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 man_ready = 1'b0;
        @(negedge clk);
        chk("hi_data", out_data, 8'h12);
        chk("hi_last", out_last, 1);
        #2 reset = 1'b1;
        sb.delete();
        #1 chk("reset_drops_valid", out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        man_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_byte", out_valid, 0);
        end

        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0: d = DW'($urandom);
                1: begin
                    r = BW'($urandom);
                    d = {{BW{r[BW-1]}}, r};
                end
                default: d = corners[$urandom_range(0, 7)];
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(d, 1'($urandom_range(0, 1)));
        end
        drain();
        rand_mode = 1'b0;

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/byte_store_unit.md
BYTE_STORE_UNIT -- requirements
Module: byte_store_unit

Interface
REQ-001 The module SHALL have parameter data_width, default 16, meaning the width of the input word.
REQ-002 The module SHALL have parameter byte_width, default 8, meaning the width of each output byte; data_width SHALL equal 2*byte_width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: in_data and in_byte_mode are valid.
REQ-006 Port in_ready, output, 1 bit: the unit accepts a word this cycle.
REQ-007 Port in_data, input, data_width bits: the word to store.
REQ-008 Port in_byte_mode, input, 1 bit: 1 selects a narrowed single-byte store; 0 selects a two-byte word store.
REQ-009 Port out_valid, output, 1 bit: out_data, out_last and overflow are valid.
REQ-010 Port out_ready, input, 1 bit: the sink accepts the byte this cycle.
REQ-011 Port out_data, output, byte_width bits: the output byte.
REQ-012 Port out_last, output, 1 bit: the current byte is the final byte of the transaction.
REQ-013 Port overflow, output, 1 bit: in byte mode, the latched word does not fit in byte_width signed bits.

Function
REQ-014 An input handshake SHALL occur when in_valid=1 and in_ready=1 at a rising edge of clk.
REQ-015 An output handshake SHALL occur when out_valid=1 and out_ready=1 at a rising edge of clk.
REQ-016 The FSM SHALL have three states: IDLE, LO and HI.
REQ-017 The unit SHALL drive in_ready=1 only in IDLE and out_valid=1 only in LO or HI.
REQ-018 An input handshake in IDLE SHALL latch in_data and in_byte_mode and move the FSM to LO, so out_valid rises exactly one cycle after acceptance.
REQ-019 In LO with a latched word, out_data SHALL equal data[byte_width-1:0] and out_last SHALL be 0; an output handshake SHALL move the FSM to HI.
REQ-020 In HI, out_data SHALL equal data[data_width-1:byte_width] and out_last SHALL be 1; an output handshake SHALL move the FSM to IDLE.
REQ-021 In LO with a latched byte, out_last SHALL be 1; an output handshake SHALL move the FSM to IDLE.
REQ-022 In LO with a latched byte, overflow SHALL be 1 iff data[data_width-1:byte_width] differs from byte_width copies of data[byte_width-1]; overflow is the inverse check of sign extension.
REQ-023 overflow SHALL be 0 in word mode and whenever out_valid=0.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_last and overflow SHALL hold stable and the FSM SHALL not advance.
REQ-025 in_valid SHALL be ignored outside IDLE, and no input SHALL be lost or duplicated.
REQ-026 The unit SHALL insert one IDLE bubble cycle between consecutive transactions.

Reset
REQ-027 While reset=1, the FSM SHALL be IDLE, with out_valid=0, out_last=0, overflow=0, out_data=0 and in_ready=0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-029 A reset asserted in LO or HI SHALL discard the pending transaction, and no remaining byte SHALL be emitted after release.

Configuration
REQ-030 When macro BYTE_STORE_SATURATE_EN is undefined, an overflowing byte store SHALL output data[byte_width-1:0], which is plain truncation.
REQ-031 When BYTE_STORE_SATURATE_EN is defined, an overflowing byte store SHALL output 0x7F if data[data_width-1]=0 and 0x80 if it is 1, with overflow still 1.
REQ-032 Non-overflowing stores and word stores SHALL be identical with and without the macro.

Verification
REQ-033 Byte mode, in_data=0xFFF0, out_ready=1 -> exactly one byte: out_data=0xF0, out_last=1, overflow=0, one cycle after acceptance.
REQ-034 Byte mode, in_data=0x0123 -> overflow=1, out_data=0x23 (macro off) or 0x7F (macro on); in_data=0x8000 -> overflow=1, out_data=0x00 or 0x80 respectively.
REQ-035 Word mode, in_data=0xBEEF -> two bytes: 0xEF with out_last=0, then 0xBE with out_last=1, overflow=0 on both; in_ready=1 again in the following cycle.
REQ-036 Word 0xBEEF with out_ready held 0 for 3 cycles in LO -> out_data stays 0xEF, in_ready stays 0, and a new in_valid pulse is ignored; the 0xBE byte follows once out_ready=1.
REQ-037 Reset pulsed while in HI for word 0x1234 -> out_valid falls to 0 immediately, 0x12 is never emitted, and in_ready=1 in the first cycle after release.
